// File: rtl/mlp_frame_loader.sv
// Serial-to-parallel front end for the MLP denoiser: converts signed samples to
// sign/magnitude, keeps a sliding window, launches frames and tracks MLP latency.
module mlp_frame_loader #(
  parameter int N1     = 98,
  parameter int W_X    = 4,
  parameter int W_S    = 8,
  parameter int SHIFT  = 2,
  parameter int STRIDE = 7,
  parameter int LAT    = 12,
  parameter int W_FID  = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          s_valid,
  input  logic [W_S-1:0]                s_data,
  output logic                          s_ready,
  output logic [N1/2-1:0][W_X-1:0]      in_mag,
  output logic [N1/2-1:0]               in_pol,
  output logic                          frame_valid,
  output logic [W_FID-1:0]              frame_id,
  output logic                          y_valid,
  output logic [W_FID-1:0]              y_id
);

  localparam int NW = N1 / 2;
  localparam int CW = $clog2(NW + 1);
  localparam int SW = $clog2(STRIDE + 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_SLIDE = 1'b1
  } state_e;

  // {mag, pol}; the most negative input has no positive twin, so abs is kept unsigned
  function automatic logic [W_X:0] to_sign_mag(input logic [W_S-1:0] x);
    logic           pol;
    logic [W_S-1:0] abs_v;
    logic [W_S-1:0] m;
    logic [W_X-1:0] mag;
    pol   = x[W_S-1];
    abs_v = pol ? (~x + {{(W_S-1){1'b0}}, 1'b1}) : x;
    m     = abs_v >> SHIFT;
    if (m > W_S'((1 << W_X) - 1)) begin
      mag = {W_X{1'b1}};
    end else begin
      mag = m[W_X-1:0];
    end
    return {mag, pol};
  endfunction

  logic                     accept_s;
  logic                     launch_s;
  logic [W_X:0]             conv_s;

  state_e                   state_q, state_d;
  logic [CW-1:0]            fill_q, fill_d;
  logic [SW-1:0]            stride_q, stride_d;
  logic [NW-1:0][W_X-1:0]   win_mag_q, win_mag_d;
  logic [NW-1:0]            win_pol_q, win_pol_d;

  logic [NW-1:0][W_X-1:0]   in_mag_q;
  logic [NW-1:0]            in_pol_q;
  logic                     fv_q;
  logic [W_FID-1:0]         fid_q;
  logic [W_FID-1:0]         nid_q;

  logic [LAT-1:0]           dl_v_q;
  logic [LAT-1:0][W_FID-1:0] dl_id_q;

  assign s_ready  = rstn & ~flush;
  assign accept_s = s_valid & s_ready;
  assign conv_s   = to_sign_mag(s_data);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave FILL on the sample that completes the first window
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FILL;
    end else if (accept_s && (state_q == ST_FILL) && (fill_q == CW'(NW - 1))) begin
      state_d = ST_SLIDE;
    end else begin
      state_d = state_q;
    end
  end

  // FSM output: frame launch decision for the sample being accepted
  always_comb begin
    launch_s = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_FILL:  launch_s = (fill_q == CW'(NW - 1));
        ST_SLIDE: launch_s = (stride_q == SW'(STRIDE - 1));
        default:  launch_s = 1'b0;
      endcase
    end else begin
      launch_s = 1'b0;
    end
  end

  // Fill and stride counters advance only on accepted samples
  always_comb begin
    fill_d   = fill_q;
    stride_d = stride_q;
    if (flush) begin
      fill_d   = '0;
      stride_d = '0;
    end else if (accept_s) begin
      case (state_q)
        ST_FILL: begin
          fill_d   = fill_q + CW'(1);
          stride_d = '0;
        end
        ST_SLIDE: begin
          fill_d   = fill_q;
          stride_d = launch_s ? '0 : (stride_q + SW'(1));
        end
        default: begin
          fill_d   = '0;
          stride_d = '0;
        end
      endcase
    end else begin
      fill_d   = fill_q;
      stride_d = stride_q;
    end
  end

  // Window shift: oldest sample at index 0, newest enters at the top
  always_comb begin
    win_mag_d = win_mag_q;
    win_pol_d = win_pol_q;
    if (flush) begin
      win_mag_d = '0;
      win_pol_d = '0;
    end else if (accept_s) begin
      for (int i = 0; i < NW - 1; i++) begin
        win_mag_d[i] = win_mag_q[i+1];
        win_pol_d[i] = win_pol_q[i+1];
      end
      win_mag_d[NW-1] = conv_s[W_X:1];
      win_pol_d[NW-1] = conv_s[0];
    end else begin
      win_mag_d = win_mag_q;
      win_pol_d = win_pol_q;
    end
  end

  // Window and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q    <= '0;
      stride_q  <= '0;
      win_mag_q <= '0;
      win_pol_q <= '0;
    end else begin
      fill_q    <= fill_d;
      stride_q  <= stride_d;
      win_mag_q <= win_mag_d;
      win_pol_q <= win_pol_d;
    end
  end

  // Frame bus: loads the post-shift window on launch and holds it otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_mag_q <= '0;
      in_pol_q <= '0;
      fv_q     <= 1'b0;
      fid_q    <= '0;
      nid_q    <= '0;
    end else begin
      fv_q <= launch_s;
      if (launch_s) begin
        in_mag_q <= win_mag_d;
        in_pol_q <= win_pol_d;
        fid_q    <= nid_q;
        nid_q    <= nid_q + W_FID'(1);
      end else begin
        in_mag_q <= in_mag_q;
        in_pol_q <= in_pol_q;
        fid_q    <= fid_q;
        nid_q    <= nid_q;
      end
    end
  end

  // Latency delay line mirroring the MLP pipeline depth; flush leaves it running
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dl_v_q  <= '0;
      dl_id_q <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        dl_v_q[i]  <= dl_v_q[i-1];
        dl_id_q[i] <= dl_id_q[i-1];
      end
      dl_v_q[0]  <= fv_q;
      dl_id_q[0] <= fid_q;
    end
  end

  assign in_mag      = in_mag_q;
  assign in_pol      = in_pol_q;
  assign frame_valid = fv_q;
  assign frame_id    = fid_q;
  assign y_valid     = dl_v_q[LAT-1];
  assign y_id        = dl_id_q[LAT-1];

endmodule

// File: tb/tb_mlp_frame_loader.sv
// Directed bench for mlp_frame_loader: a reference window model predicts frames
// and MLP-output timing into queues that are drained as the DUT produces them.
module tb_mlp_frame_loader;

  localparam int NW     = 49;
  localparam int WX     = 4;
  localparam int LAT    = 12;
  localparam int STRIDE = 7;

  logic                   clk;
  logic                   rstn;
  logic                   flush;
  logic                   s_valid;
  logic [7:0]             s_data;
  logic                   s_ready;
  logic [NW-1:0][WX-1:0]  in_mag;
  logic [NW-1:0]          in_pol;
  logic                   frame_valid;
  logic [7:0]             frame_id;
  logic                   y_valid;
  logic [7:0]             y_id;

  mlp_frame_loader #(
    .N1(98), .W_X(WX), .W_S(8), .SHIFT(2), .STRIDE(STRIDE), .LAT(LAT), .W_FID(8)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .in_mag(in_mag), .in_pol(in_pol), .frame_valid(frame_valid),
    .frame_id(frame_id), .y_valid(y_valid), .y_id(y_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int                 cyc;
    logic [7:0]         id;
    logic [NW*WX-1:0]   mag;
    logic [NW-1:0]      pol;
  } frm_t;

  typedef struct {
    int         cyc;
    logic [7:0] id;
  } yexp_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  frm_t  fq[$];
  yexp_t yq[$];

  int         wm[NW];
  int         wp[NW];
  int         fill_m;
  int         stride_m;
  bit         slide_m;
  logic [7:0] nid_m;

  logic [NW*WX-1:0] hold_mag;
  logic [NW-1:0]    hold_pol;
  logic [7:0]       hold_id;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus contents are checked every cycle against the last frame the model launched
  task automatic monitor();
    bit    efv;
    bit    eyv;
    frm_t  f;
    yexp_t y;
    efv = (fq.size() > 0) && (fq[0].cyc == cyc);
    chk("frame_valid", 256'(frame_valid), 256'(efv));
    if (efv) begin
      f        = fq.pop_front();
      hold_mag = f.mag;
      hold_pol = f.pol;
      hold_id  = f.id;
      y.cyc    = cyc + LAT;
      y.id     = f.id;
      yq.push_back(y);
    end
    chk("in_mag", 256'(in_mag), 256'(hold_mag));
    chk("in_pol", 256'(in_pol), 256'(hold_pol));
    chk("frame_id", 256'(frame_id), 256'(hold_id));
    eyv = (yq.size() > 0) && (yq[0].cyc == cyc);
    chk("y_valid", 256'(y_valid), 256'(eyv));
    if (eyv) begin
      y = yq.pop_front();
      chk("y_id", 256'(y_id), 256'(y.id));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      wm[i] = 0;
      wp[i] = 0;
    end
    fill_m   = 0;
    stride_m = 0;
    slide_m  = 1'b0;
  endtask

  task automatic model_launch();
    frm_t f;
    f.cyc = cyc + 1;
    f.id  = nid_m;
    for (int i = 0; i < NW; i++) begin
      f.mag[i*WX +: WX] = WX'(wm[i]);
      f.pol[i]          = wp[i][0];
    end
    fq.push_back(f);
    nid_m = nid_m + 8'd1;
  endtask

  task automatic model_accept(input int x);
    int a;
    int m;
    a = (x < 0) ? -x : x;
    m = a / 4;
    if (m > 15) m = 15;
    for (int i = 0; i < NW - 1; i++) begin
      wm[i] = wm[i+1];
      wp[i] = wp[i+1];
    end
    wm[NW-1] = m;
    wp[NW-1] = (x < 0) ? 1 : 0;
    if (!slide_m) begin
      fill_m++;
      if (fill_m == NW) begin
        model_launch();
        slide_m  = 1'b1;
        stride_m = 0;
      end
    end else begin
      stride_m++;
      if (stride_m == STRIDE) begin
        model_launch();
        stride_m = 0;
      end
    end
  endtask

  task automatic send(input int x);
    s_valid = 1'b1;
    s_data  = 8'(x);
    model_accept(x);
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic do_flush();
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    #1;
    chk("s_ready_flush", 256'(s_ready), 256'(1'b0));
    model_clear();
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_mag"}, 256'(in_mag), 256'(0));
    chk({tag, "_in_pol"}, 256'(in_pol), 256'(0));
    chk({tag, "_frame_valid"}, 256'(frame_valid), 256'(0));
    chk({tag, "_frame_id"}, 256'(frame_id), 256'(0));
    chk({tag, "_y_valid"}, 256'(y_valid), 256'(0));
    chk({tag, "_y_id"}, 256'(y_id), 256'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    fq.delete();
    yq.delete();
    hold_mag = '0;
    hold_pol = '0;
    hold_id  = 8'd0;
    nid_m    = 8'd0;
    model_clear();
    check_all_zero("async_reset");
    chk("s_ready_reset", 256'(s_ready), 256'(1'b0));
    idle(2);
    rstn = 1'b1;
  endtask

  initial begin
    rstn     = 1'b0;
    flush    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'd0;
    hold_mag = '0;
    hold_pol = '0;
    hold_id  = 8'd0;
    nid_m    = 8'd0;
    model_clear();

    #3;
    check_all_zero("reset");
    idle(2);
    rstn = 1'b1;

    // Fill: samples 1..49 back to back, first frame
    for (int v = 1; v <= 49; v++) send(v);
    chk("fill_mag0", 256'(in_mag[0]), 256'(0));
    chk("fill_mag48", 256'(in_mag[48]), 256'(12));
    chk("fill_id", 256'(frame_id), 256'(0));
    idle(LAT + 2);

    // Slide: 7 more samples, second frame
    for (int v = 50; v <= 56; v++) send(v);
    chk("slide_mag0", 256'(in_mag[0]), 256'(2));
    chk("slide_mag48", 256'(in_mag[48]), 256'(14));
    chk("slide_id", 256'(frame_id), 256'(1));

    // Gaps: random idle cycles between accepted samples within two strides
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < STRIDE; i++) begin
        send(rnd_sample());
        idle(int'($urandom_range(0, 3)));
      end
    end

    // Flush with a frame still in flight, partial refill, flush again
    do_flush();
    for (int i = 0; i < 30; i++) send(rnd_sample());
    do_flush();

    // Conversion: 44 fillers then the corner-case samples in the top slots
    for (int i = 0; i < 44; i++) send(rnd_sample());
    send(-37);
    send(100);
    send(-128);
    send(3);
    send(0);
    chk("conv_id", 256'(frame_id), 256'(4));
    chk("conv_m44", 256'(in_mag[44]), 256'(9));
    chk("conv_p44", 256'(in_pol[44]), 256'(1));
    chk("conv_m45", 256'(in_mag[45]), 256'(15));
    chk("conv_p45", 256'(in_pol[45]), 256'(0));
    chk("conv_m46", 256'(in_mag[46]), 256'(15));
    chk("conv_p46", 256'(in_pol[46]), 256'(1));
    chk("conv_m47", 256'(in_mag[47]), 256'(0));
    chk("conv_p47", 256'(in_pol[47]), 256'(0));
    chk("conv_m48", 256'(in_mag[48]), 256'(0));
    chk("conv_p48", 256'(in_pol[48]), 256'(0));

    // Two back-to-back strides, then reset mid-stride with both frames in flight
    for (int i = 0; i < 2 * STRIDE + 3; i++) send(rnd_sample());
    chk("inflight_count", 256'(yq.size()), 256'(2));
    do_reset();
    idle(LAT + 8);

    // Restart after reset: ids begin again at 0
    for (int i = 0; i < NW; i++) send(rnd_sample());
    chk("restart_id", 256'(frame_id), 256'(0));
    idle(LAT + 2);

    chk("frames_drained", 256'(fq.size()), 256'(0));
    chk("yout_drained", 256'(yq.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mlp_frame_loader.md
Name: mlp_frame_loader

Overview:
- Front-end stage that feeds the first-layer inputs of the MLP denoiser.
- Accepts a serial stream of signed samples and converts each one to sign/magnitude form.
- Builds a sliding window of N1/2 samples and launches a window onto the parallel in_mag/in_pol bus each time a frame completes.
- Tracks the MLP pipeline latency so downstream logic knows which output cycle belongs to which frame.

Parameters:
- N1, 98: MLP input width; the window holds N1/2 = 49 samples.
- W_X, 4: magnitude width presented to the MLP.
- W_S, 8: input sample width, two's complement.
- SHIFT, 2: right shift applied to |sample| before saturation.
- STRIDE, 7: new samples between successive frames once the window is full; legal range 1..N1/2.
- LAT, 12: MLP latency in cycles, from in_mag/in_pol load to a valid MLP output.
- W_FID, 8: frame id width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous window clear.
- s_valid  in  1  sample valid.
- s_data  in  W_S  signed sample.
- s_ready  out  1  sample ready.
- in_mag  out  [N1/2-1:0][W_X-1:0]  window magnitudes, index 0 = oldest sample.
- in_pol  out  [N1/2-1:0]  window polarities, 1 = negative.
- frame_valid  out  1  one-cycle pulse: in_mag/in_pol hold a new frame this cycle.
- frame_id  out  W_FID  id of the frame currently on in_mag/in_pol.
- y_valid  out  1  MLP output for a frame is valid this cycle.
- y_id  out  W_FID  id of that frame.

Behaviour:
- Reset and clocking: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: in_mag=0, in_pol=0, frame_valid=0, frame_id=0, y_valid=0, y_id=0, internal window=0, fill count=0, stride count=0, next-id counter=0, FSM=FILL, latency delay line all 0.
- Handshake: s_ready = rstn & ~flush, combinational. A sample is accepted when s_valid & s_ready. The block never stalls otherwise, because the MLP is fully pipelined.
- Conversion (per accepted sample x):
  - pol = x[W_S-1].
  - abs = pol ? -x : x, taken as unsigned W_S bits, so -2^(W_S-1) gives 2^(W_S-1).
  - m = abs >> SHIFT.
  - mag = (m > 2^W_X-1) ? 2^W_X-1 : m.
- Window: each accepted sample shifts the window, win[i] <= win[i+1] and win[N1/2-1] <= {mag,pol}.
- FSM FILL: the fill count increments per accepted sample. When the accepted sample brings the count to N1/2, a frame launches and the FSM goes to SLIDE with stride count=0.
- FSM SLIDE: the stride count increments per accepted sample. When it reaches STRIDE, a frame launches and the count resets to 0.
- Frame launch, at the clock edge that accepts the completing sample:
  - in_mag/in_pol load the post-shift window, which includes that sample.
  - frame_valid=1 for exactly the next cycle.
  - frame_id = next-id counter, which then increments and wraps modulo 2^W_FID.
  - in_mag/in_pol hold their value until the next launch. Shifting of the internal window never disturbs them.
- Latency tracking: a LAT-deep shift register carries {frame_valid, frame_id}. y_valid/y_id equal the frame_valid/frame_id values from exactly LAT cycles earlier. Several frames may be in flight, up to ceil(LAT/STRIDE).
- Flush (sync, one cycle): clears the window, fill count and stride count, and sets the FSM to FILL. No sample is accepted in that cycle.
  - Flush does not clear in_mag/in_pol, the next-id counter, or the latency delay line. In-flight frames still produce y_valid.
- Reset mid-operation: everything returns to reset values immediately. In-flight frames are dropped and no y_valid is produced for them.
- Gaps in s_valid pause all counters. Launch depends only on the count of accepted samples, not on cycles.
- STRIDE=N1/2 gives non-overlapping frames. STRIDE=1 gives a launch on every accepted sample after fill.

Test Plan:
- Conversion: with SHIFT=2, W_X=4, feed x=-37, 100, -128, 3, 0. Required {mag,pol}: {9,1}, {15,0}, {15,1}, {0,0}, {0,0}. Check by filling a frame and reading the top 5 window slots.
- Fill and launch: after reset, stream samples 1..49 back-to-back. frame_valid pulses once, the cycle after sample 49 is accepted. frame_id=0. in_mag[0]=0 (sample 1>>2) and in_mag[48]=12 (sample 49>>2). y_valid pulses exactly 12 cycles later with y_id=0.
- Slide: continue with 7 more samples. A second frame launches with frame_id=1. in_mag[0] is the magnitude of sample 8 and in_mag[48] that of sample 56. in_mag/in_pol stay unchanged during the 6 intermediate accepts.
- Gaps: insert random s_valid=0 gaps during a stride. The launch still occurs on the 7th accepted sample. The y_valid spacing matches the frame_valid spacing.
- Flush: assert flush after 30 of 49 fill samples, with a frame still in flight. s_ready=0 that cycle and the in-flight y_valid is still produced. The next frame needs a full 49 new samples, and its id continues the sequence.
- Reset: drop rstn mid-stride with 2 frames in flight. All outputs read 0 immediately, and no y_valid appears afterwards until new frames launch.
